// File: rtl/spi_slave.sv
// Mode-0 SPI slave: the external SCK/CS_N/MOSI are synchronised and oversampled in sys_clk, with a one-entry tx holding buffer.
// Latency: rx_valid comes 3 sys_clk after the last SCK rise at the pin; there is no rx backpressure, and tx_ready drops while the buffer is full.
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         sck_q, cs_q;
    logic [1:0]         mosi_q;
    logic [1:0]         prime;
    logic               armed;
    logic               buf_full;
    logic [DATA_W-1:0]  buf_dat;
    logic [DATA_W-1:0]  tx_sh;
    logic [DATA_W-1:0]  rx_sh;
    logic [DATA_W-1:0]  rx_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic               reload;
    logic               sck_rise, sck_fall, cs_rise, cs_fall;
    logic               start, load, wr;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck};
            cs_q   <= {cs_q[1:0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign rx_next  = {rx_sh[DATA_W-2:0], mosi_q[1]};

    // The synchroniser holds its reset value for two cycles, so CS_N can only
    // arm the slave once it really reflects the pin.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            prime <= 2'b00;
            armed <= 1'b0;
        end else begin
            prime <= {prime[0], 1'b1};
            if (prime[1] && cs_q[1])
                armed <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr   = tx_valid && !buf_full;
    assign load = start || (state_q == ACTIVE && !cs_rise && sck_fall && reload);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            buf_full    <= 1'b0;
            buf_dat     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            reload      <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (load) begin
                if (buf_full) begin
                    tx_sh    <= buf_dat;
                    buf_full <= 1'b0;
                end else begin
                    tx_sh       <= '0;
                    tx_underrun <= 1'b1;
                end
            end
            // A write only happens into an empty buffer, so it never races a drain.
            if (wr) begin
                buf_full <= 1'b1;
                buf_dat  <= tx_data;
            end
            if (start || (state_q == ACTIVE && cs_rise)) begin
                bit_cnt <= '0;
                reload  <= 1'b0;
            end else if (state_q == ACTIVE) begin
                if (sck_rise) begin
                    rx_sh <= rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        reload   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (sck_fall) begin
                    if (reload) reload <= 1'b0;
                    else        tx_sh  <= tx_sh << 1;
                end
            end
        end
    end

    assign tx_ready    = !buf_full;
    assign spi_miso_oe = (state_q == ACTIVE);
    assign spi_miso    = (state_q == ACTIVE) ? tx_sh[DATA_W-1] : 1'b0;

endmodule
